// File: rtl/alu_issue_ctrl.sv
// Issue controller for the DSP48E1 alu_core: decodes tagged requests,
// skews operand/control delivery, stalls ALU-stage collisions, and
// returns each result with its tag after a fixed latency.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake
//   in_op/in_a/in_b/in_c     op code and operands
//   in_tag                   requester tag
//   a_o,b_o,c_o              operands to the core
//   opmode_o,alumode_o,
//   inmode_o,usemult_o       control to the core
//   p_i                      result from the core
//   res_valid/data/tag       result strobe, value and tag
//   err_illegal              pulse on acceptance of op 6/7
module alu_issue_ctrl #(
   parameter int D_SKEW  = 1,
   parameter int ALU_LAT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [29:0] in_a,
   input  logic [17:0] in_b,
   input  logic [47:0] in_c,
   input  logic [3:0]  in_tag,
   output logic [29:0] a_o,
   output logic [17:0] b_o,
   output logic [47:0] c_o,
   output logic [6:0]  opmode_o,
   output logic [3:0]  alumode_o,
   output logic [4:0]  inmode_o,
   output logic        usemult_o,
   input  logic [47:0] p_i,
   output logic        res_valid,
   output logic [47:0] res_data,
   output logic [3:0]  res_tag,
   output logic        err_illegal
);

   // Z=P, X=Y=0: holds P so ACC chains survive idle gaps
   localparam logic [6:0] OPM_IDLE = 7'b0100000;

   typedef struct packed {
      logic        v;
      logic [47:0] c;
      logic [6:0]  opm;
      logic [3:0]  alu;
      logic [3:0]  tag;
   } slot_t;

   logic        w_mult;
   logic        w_alu;
   logic        w_ill;
   logic [6:0]  w_opm;
   logic [3:0]  w_alum;
   logic        w_use;
   logic        w_ready;
   logic        w_acc;
   slot_t       w_new;

   // r_pend[k] reaches the ctrl outputs k+1 edges from now
   slot_t               r_pend [D_SKEW];
   // delay line keyed on the ctrl slot; index k = slot + k
   logic [ALU_LAT:0]       r_dv;
   logic [ALU_LAT:0][3:0]  r_dt;

   always_comb begin
      w_mult = 1'b0;
      w_alu  = 1'b0;
      w_ill  = 1'b0;
      w_opm  = OPM_IDLE;
      w_alum = 4'b0000;
      w_use  = 1'b0;
      unique case (in_op)
         3'd0: begin
            w_mult = 1'b1;
            w_opm  = 7'b0000101;
            w_use  = 1'b1;
         end
         3'd1: begin
            w_mult = 1'b1;
            w_opm  = 7'b0110101;
            w_use  = 1'b1;
         end
         3'd2: begin
            w_alu = 1'b1;
            w_opm = 7'b0110011;
         end
         3'd3: begin
            w_alu  = 1'b1;
            w_opm  = 7'b0110011;
            w_alum = 4'b0011;
         end
         3'd4: begin
            w_alu = 1'b1;
            w_opm = 7'b0110000;
         end
         3'd5: begin
            w_mult = 1'b1;
            w_opm  = 7'b0100101;
            w_use  = 1'b1;
         end
         default: w_ill = 1'b1;
      endcase
   end

   // only ALU ops can collide: their slot (next cycle) may hold a
   // mult op accepted D_SKEW cycles earlier
   assign w_ready  = !rst && !(w_alu && r_pend[0].v);
   assign in_ready = w_ready;
   assign w_acc    = in_valid && w_ready;
   assign w_new    = {1'b1, in_c, w_opm, w_alum, in_tag};
   assign inmode_o = 5'b00000;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_o         <= '0;
         b_o         <= '0;
         usemult_o   <= 1'b0;
         c_o         <= '0;
         opmode_o    <= OPM_IDLE;
         alumode_o   <= '0;
         for (int k = 0; k < D_SKEW; k++)
            r_pend[k] <= '0;
         r_dv        <= '0;
         r_dt        <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_tag     <= '0;
         err_illegal <= 1'b0;
      end else begin
         err_illegal <= w_acc && w_ill;
         if (w_acc && !w_ill) begin
            a_o       <= in_a;
            b_o       <= in_b;
            usemult_o <= w_use;
         end else begin
            a_o       <= '0;
            b_o       <= '0;
            usemult_o <= 1'b0;
         end
         for (int k = 0; k < D_SKEW - 1; k++)
            r_pend[k] <= r_pend[k+1];
         r_pend[D_SKEW-1] <= (w_acc && w_mult) ? w_new : '0;
         if (w_acc && w_alu) begin
            c_o       <= in_c;
            opmode_o  <= w_opm;
            alumode_o <= w_alum;
            r_dv[0]   <= 1'b1;
            r_dt[0]   <= in_tag;
         end else if (r_pend[0].v) begin
            c_o       <= r_pend[0].c;
            opmode_o  <= r_pend[0].opm;
            alumode_o <= r_pend[0].alu;
            r_dv[0]   <= 1'b1;
            r_dt[0]   <= r_pend[0].tag;
         end else begin
            c_o       <= '0;
            opmode_o  <= OPM_IDLE;
            alumode_o <= '0;
            r_dv[0]   <= 1'b0;
            r_dt[0]   <= '0;
         end
         for (int k = 1; k <= ALU_LAT; k++) begin
            r_dv[k] <= r_dv[k-1];
            r_dt[k] <= r_dt[k-1];
         end
         res_valid <= r_dv[ALU_LAT];
         if (r_dv[ALU_LAT]) begin
            res_data <= p_i;
            res_tag  <= r_dt[ALU_LAT];
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural DSP core, acceptance-order
// result scoreboard, decode table, corner sequences and random traffic.
module tb_alu_issue_ctrl;

   localparam int DS = 1;
   localparam int AL = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [29:0] in_a;
   logic [17:0] in_b;
   logic [47:0] in_c;
   logic [3:0]  in_tag;
   logic [29:0] a_o;
   logic [17:0] b_o;
   logic [47:0] c_o;
   logic [6:0]  opmode_o;
   logic [3:0]  alumode_o;
   logic [4:0]  inmode_o;
   logic        usemult_o;
   logic [47:0] p_i;
   logic        res_valid;
   logic [47:0] res_data;
   logic [3:0]  res_tag;
   logic        err_illegal;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.D_SKEW(DS), .ALU_LAT(AL)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .in_c(in_c), .in_tag(in_tag),
      .a_o(a_o), .b_o(b_o), .c_o(c_o),
      .opmode_o(opmode_o), .alumode_o(alumode_o),
      .inmode_o(inmode_o), .usemult_o(usemult_o),
      .p_i(p_i),
      .res_valid(res_valid), .res_data(res_data),
      .res_tag(res_tag), .err_illegal(err_illegal)
   );

   function automatic logic [47:0] mulm(logic [29:0] a, logic [17:0] b);
      logic signed [47:0] sa, sb;
      sa = $signed(a[24:0]);
      sb = $signed(b);
      return sa * sb;
   endfunction

   // behavioural DSP core: multiplier path lags DS cycles, P after AL
   logic [29:0] ad [DS];
   logic [17:0] bd [DS];
   logic [47:0] pl [AL];
   logic [47:0] core_x, core_z, core_n;

   always_comb begin
      core_x = '0;
      core_z = '0;
      if (opmode_o[1:0] == 2'b01)
         core_x = mulm(ad[DS-1], bd[DS-1]);
      else if (opmode_o[1:0] == 2'b11)
         core_x = {a_o, b_o};
      if (opmode_o[6:4] == 3'b010)
         core_z = pl[0];
      else if (opmode_o[6:4] == 3'b011)
         core_z = c_o;
      core_n = (alumode_o == 4'b0011) ? core_z - core_x : core_z + core_x;
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DS; k++) begin
            ad[k] <= '0;
            bd[k] <= '0;
         end
         for (int k = 0; k < AL; k++)
            pl[k] <= '0;
      end else begin
         ad[0] <= a_o;
         bd[0] <= b_o;
         for (int k = 1; k < DS; k++) begin
            ad[k] <= ad[k-1];
            bd[k] <= bd[k-1];
         end
         pl[0] <= core_n;
         for (int k = 1; k < AL; k++)
            pl[k] <= pl[k-1];
      end
   end
   assign p_i = pl[AL-1];

   typedef struct {
      logic [47:0] data;
      logic [3:0]  tag;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [29:0] a;
      logic [17:0] b;
      logic [47:0] c;
      logic [3:0]  tag;
      logic [6:0]  opm;
      logic [3:0]  alum;
      logic        use_m;
      logic [47:0] res;
   } vec_t;

   exp_t        q[$];
   int          slots[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          exp_err = -1;
   logic [47:0] last_p = '0;
   bit          last_acc;
   bit          use_tbl = 0;
   logic [47:0] tbl_res;
   vec_t        tv [8];

   function automatic bit is_mult(logic [2:0] op);
      return op == 3'd0 || op == 3'd1 || op == 3'd5;
   endfunction

   function automatic bit is_alu(logic [2:0] op);
      return op == 3'd2 || op == 3'd3 || op == 3'd4;
   endfunction

   function automatic bit slot_taken(int s);
      foreach (slots[i])
         if (slots[i] == s) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [47:0] ref_res(logic [2:0] op, logic [29:0] a,
         logic [17:0] b, logic [47:0] c, logic [47:0] lp);
      case (op)
         3'd0: return mulm(a, b);
         3'd1: return mulm(a, b) + c;
         3'd2: return {a, b} + c;
         3'd3: return c - {a, b};
         3'd4: return c;
         default: return lp + mulm(a, b);
      endcase
   endfunction

   task automatic chk(string nm, logic [47:0] act, logic [47:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      logic [47:0] d;
      int lat;
      @(negedge clk);
      chk("in_ready", in_ready,
          !rst && !(is_alu(in_op) && slot_taken(cyc + 1)));
      last_acc = 0;
      if (rst) begin
         q.delete();
         slots.delete();
         last_p  = '0;
         exp_err = -1;
      end else if (in_valid && in_ready) begin
         last_acc = 1;
         if (in_op >= 3'd6) begin
            exp_err = cyc + 1;
         end else begin
            lat = is_mult(in_op) ? DS + AL + 2 : AL + 2;
            d = use_tbl ? tbl_res
                        : ref_res(in_op, in_a, in_b, in_c, last_p);
            last_p = d;
            q.push_back('{d, in_tag, cyc + lat});
            slots.push_back(cyc + 1 + (is_mult(in_op) ? DS : 0));
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         n_chk++;
         n_fail++;
         $display("FAIL missing result: tag %0h due cycle %0d not seen",
                  q[0].tag, q[0].cyc);
         void'(q.pop_front());
      end
      chk("err_illegal", err_illegal, cyc == exp_err);
      if (res_valid) begin
         if (q.size() > 0 && q[0].cyc == cyc) begin
            chk("res_data", res_data, q[0].data);
            chk("res_tag", res_tag, q[0].tag);
            void'(q.pop_front());
         end else begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected res_valid: tag %0h data %0h cycle %0d",
                     res_tag, res_data, cyc);
         end
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [29:0] a,
         input logic [17:0] b, input logic [47:0] c,
         input logic [3:0] tag, output int n);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_c     = c;
      in_tag   = tag;
      n = 0;
      do begin
         tick();
         n++;
      end while (!last_acc && n < 4);
      if (!last_acc) chk("accept_timeout", 48'd0, 48'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_op    = 3'd0;
      repeat (n) tick();
   endtask

   task automatic drain(input int budget);
      int i;
      in_valid = 1'b0;
      i = 0;
      while (q.size() > 0 && i < budget) begin
         tick();
         i++;
      end
      if (q.size() > 0) chk("drain_timeout", q.size(), 0);
      repeat (2) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tv[0] = '{3'd0, 30'd3, 18'h3FFFB, 48'd0, 4'd1,
                7'b0000101, 4'b0000, 1'b1, 48'hFFFF_FFFF_FFF1};
      tv[1] = '{3'd1, 30'd4, 18'd5, 48'd10, 4'd2,
                7'b0110101, 4'b0000, 1'b1, 48'd30};
      tv[2] = '{3'd2, 30'd0, 18'd40, 48'd60, 4'd3,
                7'b0110011, 4'b0000, 1'b0, 48'd100};
      tv[3] = '{3'd3, 30'd0, 18'd40, 48'd100, 4'd4,
                7'b0110011, 4'b0011, 1'b0, 48'd60};
      tv[4] = '{3'd4, 30'd5, 18'd6, 48'd7, 4'd5,
                7'b0110000, 4'b0000, 1'b0, 48'd7};
      tv[5] = '{3'd5, 30'd2, 18'd7, 48'd0, 4'd6,
                7'b0100101, 4'b0000, 1'b1, 48'd21};
      tv[6] = '{3'd2, 30'd1, 18'd0, 48'd5, 4'd7,
                7'b0110011, 4'b0000, 1'b0, 48'h4_0005};
      tv[7] = '{3'd0, 30'h3FFF_FFFF, 18'h3FFFF, 48'd0, 4'd8,
                7'b0000101, 4'b0000, 1'b1, 48'd1};

      rst = 1'b1;
      in_valid = 1'b0;
      in_op = '0;
      in_a = '0;
      in_b = '0;
      in_c = '0;
      in_tag = '0;
      repeat (3) tick();
      chk("rst_opmode", opmode_o, 7'b0100000);
      chk("rst_alumode", alumode_o, 0);
      chk("rst_a", a_o, 0);
      chk("rst_c", c_o, 0);
      chk("rst_usemult", usemult_o, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_tag", res_tag, 0);
      rst = 1'b0;
      idle(2);

      use_tbl = 1;
      for (int i = 0; i < 8; i++) begin
         tbl_res = tv[i].res;
         issue(tv[i].op, tv[i].a, tv[i].b, tv[i].c, tv[i].tag, n);
         chk("tbl_usemult", usemult_o, tv[i].use_m);
         chk("tbl_inmode", inmode_o, 0);
         chk("tbl_a", a_o, tv[i].a);
         chk("tbl_b", b_o, tv[i].b);
         if (!is_mult(tv[i].op)) begin
            chk("tbl_opmode", opmode_o, tv[i].opm);
            chk("tbl_alumode", alumode_o, tv[i].alum);
            chk("tbl_c", c_o, tv[i].c);
         end
         idle(1);
         chk("tbl_a_idle", a_o, 0);
         chk("tbl_usemult_idle", usemult_o, 0);
         if (is_mult(tv[i].op)) begin
            chk("tbl_opmode_skew", opmode_o, tv[i].opm);
            chk("tbl_alumode_skew", alumode_o, tv[i].alum);
            chk("tbl_c_skew", c_o, tv[i].c);
         end else begin
            chk("tbl_opmode_idle", opmode_o, 7'b0100000);
         end
         drain(12);
      end

      // mult then ALU back to back: ALU stalls exactly one cycle
      use_tbl = 0;
      issue(3'd0, 30'd6, 18'd7, 48'd0, 4'd2, n);
      chk("mul_no_stall", n, 1);
      in_op = 3'd2;
      in_a = 30'd0;
      in_b = 18'd1;
      in_c = 48'd2;
      in_tag = 4'd3;
      #1;
      chk("add_stalled", in_ready, 0);
      issue(3'd2, 30'd0, 18'd1, 48'd2, 4'd3, n);
      chk("add_stall_cycles", n, 2);
      drain(12);

      // P held through idle gap for ACC
      use_tbl = 1;
      tbl_res = 48'd60;
      issue(3'd3, 30'd0, 18'd40, 48'd100, 4'd4, n);
      idle(3);
      tbl_res = 48'd74;
      issue(3'd5, 30'd2, 18'd7, 48'd0, 4'd5, n);
      drain(12);
      use_tbl = 0;

      // full-rate PASSC stream
      for (int i = 0; i < 8; i++) begin
         issue(3'd4, 30'd0, 18'd0, 48'(i), 4'(i), n);
         chk("passc_rate", n, 1);
      end
      drain(12);

      // illegal op
      issue(3'd6, 30'd1, 18'd1, 48'd1, 4'd9, n);
      chk("ill_no_issue_a", a_o, 0);
      drain(12);
      idle(8);

      // reset two cycles after accepting MACC
      issue(3'd1, 30'd3, 18'd3, 48'd3, 4'd11, n);
      idle(1);
      rst = 1'b1;
      tick();
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_opmode", opmode_o, 7'b0100000);
      chk("mid_rst_c", c_o, 0);
      chk("mid_rst_usemult", usemult_o, 0);
      chk("mid_rst_res_valid", res_valid, 0);
      chk("mid_rst_res_data", res_data, 0);
      rst = 1'b0;
      idle(10);

      // random traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_op    = 3'($urandom_range(0, 7));
         in_a     = 30'($urandom);
         in_b     = 18'($urandom);
         in_c     = {16'($urandom), 32'($urandom)};
         in_tag   = 4'($urandom);
         tick();
      end
      drain(20);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue controller for the DSP48E1-based `alu_core` in the Chebyshev datapath. It accepts tagged operation requests over a valid/ready handshake and decodes each into `opmode`, `alumode`, `inmode` and `usemult`. It skews operand and control delivery so that multiply and non-multiply operations line up inside the DSP pipeline, and stalls requests that would collide in the ALU stage. It returns each result with its tag after a fixed, op-independent latency.

## Interface
Parameters:
- `D_SKEW`, default 1: extra cycles the multiply path needs over the C/control path before reaching the ALU stage.
- `ALU_LAT`, default 3: cycles from the control/C presentation on the core ports to `p_i` valid.

Ports:
- `clk`  in  1  the single clock for the block.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_op`  in  3  operation code.
- `in_a`  in  30  A operand.
- `in_b`  in  18  B operand.
- `in_c`  in  48  C operand.
- `in_tag`  in  4  requester tag, returned with the result.
- `a_o`  out  30  to core `a_i`.
- `b_o`  out  18  to core `b_i`.
- `c_o`  out  48  to core `c_i`.
- `opmode_o`  out  7  to core `opmode_i`.
- `alumode_o`  out  4  to core `alumode_i`.
- `inmode_o`  out  5  to core `inmode_i`.
- `usemult_o`  out  1  to core `usemult_i`.
- `p_i`  in  48  from core `p_o`.
- `res_valid`  out  1  one-cycle result strobe. There is no backpressure on this interface.
- `res_data`  out  48  registered result.
- `res_tag`  out  4  tag of the result.
- `err_illegal`  out  1  one-cycle pulse when an illegal op is accepted.

## Operation
Op decode, given as opmode / alumode / usemult (`inmode` is always 00000):
- 0 MUL: P = A*B. 0000101 / 0000 / 1.
- 1 MACC: P = A*B + C. 0110101 / 0000 / 1.
- 2 ADD: P = A:B + C. 0110011 / 0000 / 0.
- 3 SUB: P = C − A:B. 0110011 / 0011 / 0.
- 4 PASSC: P = C. 0110000 / 0000 / 0.
- 5 ACC: P = P + A*B. 0100101 / 0000 / 1.
- 6, 7 are illegal. They are accepted (`in_ready` per normal rules), nothing is issued, `err_illegal` pulses the cycle after acceptance, and no result is produced.

Issue rules:
- Acceptance at cycle t drives `a_o`, `b_o`, `inmode_o` and `usemult_o`, all registered, valid at cycle t+1.
- The ctrl slot is the cycle in which `c_o`, `opmode_o` and `alumode_o` carry the op's values.
  - Mult ops (0, 1, 5): ctrl slot is t+1+D_SKEW.
  - ALU ops (2–4): ctrl slot is t+1.
- A slot-reservation shift register (depth D_SKEW+1) marks occupied ctrl slots.
- `in_ready` = !(slot needed by the `in_op` currently presented is already reserved). `in_ready` may depend combinationally on `in_op`; it never depends on `in_ready` of a later cycle.
- With D_SKEW=1, an ALU op presented the cycle after an accepted mult op is stalled exactly one cycle. A mult op is never stalled.
- Idle values:
  - When the core port is unused: `a_o`/`b_o`/`c_o` = 0, `inmode_o` = 0, `usemult_o` = 0.
  - When the ctrl slot is unused: `opmode_o` = 0100000, `alumode_o` = 0000. This holds P, so ACC chains survive idle gaps.
- Ordering and ACC: results are in acceptance order. ACC accumulates onto the previous P value, i.e. the most recently completed op.
- Tag pipeline: a valid/tag delay line keyed on the ctrl slot. `res_data` <= `p_i` in the cycle ctrl slot + ALU_LAT, and `res_valid` is high in the following cycle.

## Timing
- Reset values: `in_ready` = 0 during reset, 1 (op-dependent) after. `a_o`/`b_o`/`c_o`/`inmode_o`/`usemult_o`/`alumode_o` = 0. `opmode_o` = 0100000. `res_valid` = 0, `res_data` = 0, `res_tag` = 0, `err_illegal` = 0.
- Latency from acceptance to `res_valid`:
  - Mult ops: D_SKEW + ALU_LAT + 2 (6 at defaults).
  - ALU ops: ALU_LAT + 2 (5 at defaults).
  - The completion cycle for each op is the ctrl slot + ALU_LAT + 1.
- Throughput: one accepted op per cycle, except for the stall above. Two results never complete in the same cycle.
- Reset mid-operation: all reservations, delay lines and in-flight results are cleared. No `res_valid` is produced for ops accepted before reset.
- `in_valid` low: nothing is reserved and idle values are driven.

## Test plan
- MUL A=3, B=−5 tag 1 at cycle 0 → `opmode_o` = 0000101 at cycle 2; `res_valid` at cycle 6 with `res_data` = −15, tag 1.
- Back-to-back MUL (tag 2) then ADD (tag 3), `in_valid` held → `in_ready` = 0 for one cycle on ADD; results arrive tag 2 then tag 3 in distinct cycles, no slot collision.
- SUB C=100, A:B=40 followed by three idle cycles then ACC A=2, B=7 → results 60, then 74 (P held through idle).
- PASSC stream of 8 ops with C=0..7 at full rate → 8 consecutive `res_valid` cycles, data 0..7, tags in order.
- Illegal op 6 tag 9 → `err_illegal` pulse one cycle after acceptance; no `res_valid` with tag 9.
- Reset asserted 2 cycles after accepting MACC → no `res_valid`; all outputs at reset values the cycle after `rst` is sampled.
